// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encoding, default timing and keyboard command bytes.
// Imported by the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int INHIBIT_CYCLES_DEF = 5000;    // 100 us at 50 MHz
  localparam int TIMEOUT_CYCLES_DEF = 750000;  // 15 ms at 50 MHz

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam logic [7:0] SET_LEDS = 8'hED;
  localparam logic [7:0] RESET    = 8'hFF;
  localparam logic [7:0] ENABLE   = 8'hF4;
  localparam logic [7:0] ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request/response handshake plus the open-drain PS/2 line pair of the host transmitter.
// master = requester/line side, slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;
  logic       PS2_Clk;
  logic       PS2_Din;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, PS2_Clk, PS2_Din,
    input  tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, PS2_Clk, PS2_Din,
    output tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// 4-stage synchronizers for the raw PS/2 clock and data lines plus a one-cycle clock falling-edge pulse.
// Fall pulse arrives two clk cycles after the line drops; no backpressure.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [3:0] clk_sh_q, clk_sh_d;
  logic [3:0] dat_sh_q, dat_sh_d;

  always_comb begin
    clk_sh_d = {clk_sh_q[2:0], ps2_clk_in};
    dat_sh_d = {dat_sh_q[2:0], ps2_dat_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sh_q <= 4'b0;
      dat_sh_q <= 4'b0;
    end else begin
      clk_sh_q <= clk_sh_d;
      dat_sh_q <= dat_sh_d;
    end
  end

  // Oldest stage as the level: data is then at least as old as a just-detected clock fall.
  assign clk_sync = clk_sh_q[3];
  assign dat_sync = dat_sh_q[3];
  assign clk_fall = (clk_sh_q[1:0] == 2'b00) && (clk_sh_q[3:2] == 2'b11);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-keyboard PS/2 frame sender: inhibit, start, 8 data LSB first, odd parity, stop, device ACK.
// Clock line pulled the cycle after accept; tx_ready low for the whole frame, requests while busy are dropped.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  ps2_host_tx_if.slave  bus
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]     state_q, state_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     frame_q, frame_d;
  logic           cur_bit_q, cur_bit_d;
  logic           ack_q, ack_d;
  logic           clk_sync, dat_sync, clk_fall;
  logic           tmo_hit, done, err, clk_oe, data_oe;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (bus.PS2_Clk),
    .ps2_dat_in (bus.PS2_Din),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  assign tmo_hit = ((state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_RELEASE))
                   && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    cur_bit_d = cur_bit_q;
    ack_d     = ack_q;
    done      = 1'b0;
    err       = 1'b0;
    clk_oe    = 1'b0;
    data_oe   = 1'b0;

    // Runs from START on, so an unanswered start bit aborts exactly TIMEOUT_CYCLES later.
    if ((state_q != ST_IDLE) && (state_q != ST_INHIBIT))
      tmo_d = clk_fall ? '0 : tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          frame_d = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
          icnt_d  = '0;
          ack_d   = 1'b0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe = 1'b1;
        if (icnt_q == ICW'(INHIBIT_CYCLES - 1)) begin
          data_oe = 1'b1;
          tmo_d   = '0;
          state_d = ST_START;
        end else begin
          icnt_d = icnt_q + ICW'(1);
        end
      end
      ST_START: begin
        data_oe   = 1'b1;
        bit_cnt_d = '0;
        cur_bit_d = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmo_hit) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          data_oe = ~cur_bit_q;
          if (clk_fall) begin
            cur_bit_d = frame_q[0];
            frame_d   = {1'b0, frame_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (tmo_hit) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          if (!dat_sync) begin
            ack_d   = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RELEASE: begin
        if (tmo_hit) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_q && clk_sync && dat_sync) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      icnt_q    <= '0;
      tmo_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      cur_bit_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      icnt_q    <= icnt_d;
      tmo_q     <= tmo_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      cur_bit_q <= cur_bit_d;
      ack_q     <= ack_d;
    end
  end

  // Line drives decode the registered state, so reset releases them without waiting for a clock.
  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.tx_ready    = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.tx_done     = done;
  assign bus.tx_err      = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, cycle timeline model of the host drive, and frame scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  bit m_busy = 1'b0;
  bit m_end  = 1'b0;
  bit exp_tmo = 1'b0;
  int m_cyc = 0;

  ps2_host_tx_if bus();

  assign bus.PS2_Clk = dev_clk & ~bus.ps2_clk_oe;
  assign bus.PS2_Din = dev_dat & ~bus.ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: cycles since accept decide what the host must drive.
  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
    end else if (!m_busy && bus.tx_valid) begin
      m_busy <= 1'b1;
      m_cyc  <= 1;
    end else if (m_busy && m_end) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk1("rst_clk_oe", bus.ps2_clk_oe, 1'b0);
      chk1("rst_data_oe", bus.ps2_data_oe, 1'b0);
      chk1("rst_done", bus.tx_done, 1'b0);
      chk1("rst_err", bus.tx_err, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_ready", bus.tx_ready, 1'b1);
    end else begin
      chk1("done_err_exclusive", bus.tx_done & bus.tx_err, 1'b0);
      if (bus.tx_done) n_done <= n_done + 1;
      if (bus.tx_err)  n_err  <= n_err + 1;
      if (!m_busy) begin
        chk1("idle_clk_oe", bus.ps2_clk_oe, 1'b0);
        chk1("idle_data_oe", bus.ps2_data_oe, 1'b0);
        chk1("idle_ready", bus.tx_ready, 1'b1);
        chk1("idle_busy", bus.busy, 1'b0);
        chk1("idle_pulse", bus.tx_done | bus.tx_err, 1'b0);
      end else begin
        chk1("frame_ready", bus.tx_ready, 1'b0);
        chk1("frame_busy", bus.busy, 1'b1);
        if (m_cyc <= INH) begin
          chk1("inhibit_clk_oe", bus.ps2_clk_oe, 1'b1);
          chk1("inhibit_data_oe", bus.ps2_data_oe, m_cyc == INH);
        end else begin
          chk1("post_inhibit_clk_oe", bus.ps2_clk_oe, 1'b0);
          if (m_cyc == INH + 1) chk1("start_data_oe", bus.ps2_data_oe, 1'b1);
          if (exp_tmo && m_cyc <= INH + 1 + TMO) begin
            chk1("timeout_err_time", bus.tx_err, m_cyc == INH + 1 + TMO);
            chk1("timeout_data_oe", bus.ps2_data_oe, m_cyc < INH + 1 + TMO);
            chk1("timeout_no_done", bus.tx_done, 1'b0);
          end
        end
        if (bus.tx_done || bus.tx_err) m_end <= 1'b1;
      end
    end
    if (!m_busy) m_end <= 1'b0;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk1("ready_before_send", bus.tx_ready, 1'b1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk1("clk_oe_cycle_after_accept", bus.ps2_clk_oe, 1'b1);
    repeat (5) @(negedge clk);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Device side: clocks 10 bits, samples on rising edges, then the ACK clock.
  task automatic dev_frame(input bit do_ack, input int abort_at, output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_data_oe == 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("start_bit_driven", bus.ps2_data_oe && !bus.ps2_clk_oe, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) begin
        #3 rst = 1'b0;
        #1;
        chk1("abort_clk_oe", bus.ps2_clk_oe, 1'b0);
        chk1("abort_data_oe", bus.ps2_data_oe, 1'b0);
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[k-1] = bus.PS2_Din;
      repeat (HALF) @(negedge clk);
    end
    if (do_ack) dev_dat = 1'b0;
    repeat (3) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit do_ack,
                           output logic [9:0] bits);
    int d0, e0, n;
    d0 = n_done;
    e0 = n_err;
    send(b);
    dev_frame(do_ack, 0, bits);
    n = 0;
    while (n_done == d0 && n_err == e0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chkv({tag, "_bits"}, int'(bits), int'({1'b1, ~^b, b}));
    chkv({tag, "_done_count"}, n_done - d0, do_ack ? 1 : 0);
    chkv({tag, "_err_count"}, n_err - e0, do_ack ? 0 : 1);
    chk1({tag, "_ready_after"}, bus.tx_ready, 1'b1);
    chk1({tag, "_lines_released"}, bus.ps2_clk_oe | bus.ps2_data_oe, 1'b0);
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_ready", bus.tx_ready, 1'b1);
    chk1("reset_busy", bus.busy, 1'b0);
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("set_leds", SET_LEDS, 1'b1, bits);
    chkv("set_leds_literal", int'(bits), 'h3ED);
    run_frame("enable", ENABLE, 1'b1, bits);
    chkv("enable_literal", int'(bits), 'h2F4);
    chk1("enable_parity", bits[8], 1'b0);
    run_frame("reset_cmd", RESET, 1'b1, bits);
    chkv("reset_cmd_literal", int'(bits), 'h3FF);
    chk1("reset_cmd_parity", bits[8], 1'b1);
    run_frame("nak", ACK, 1'b0, bits);
    chkv("nak_literal", int'(bits), 'h3FA);

    exp_tmo = 1'b1;
    d0 = n_done;
    e0 = n_err;
    send(8'h55);
    n = 0;
    while (n_err == e0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    exp_tmo = 1'b0;
    chkv("timeout_err_count", n_err - e0, 1);
    chkv("timeout_done_count", n_done - d0, 0);
    chk1("timeout_released", bus.ps2_clk_oe | bus.ps2_data_oe, 1'b0);

    d0 = n_done;
    e0 = n_err;
    send(SET_LEDS);
    dev_frame(1'b1, 5, bits);
    repeat (3) @(negedge clk);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    #3 rst = 1'b1;
    repeat (30) @(negedge clk);
    chkv("abort_done_count", n_done - d0, 0);
    chkv("abort_err_count", n_err - e0, 0);
    run_frame("after_abort", SET_LEDS, 1'b1, bits);
    chkv("after_abort_literal", int'(bits), 'h3ED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
